// File: rtl/inst_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory port, redirect input, decode-side
// valid/ready stream and status. master = fetch unit, slave = its environment.
interface inst_fetch_unit_if;
  logic [31:0] inst_add;
  logic [31:0] inst_code;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        halted;
  logic [15:0] fetch_count;

  modport master (
    output inst_add,
    input  inst_code,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output halted,
    output fetch_count
  );

  modport slave (
    input  inst_add,
    output inst_code,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  halted,
    input  fetch_count
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word per cycle into a
// 2-entry queue toward decode, handles redirects, back-pressure and halt.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = 32'h0000_0073,
  parameter int unsigned PC_STEP   = 4
) (
  input logic              clk,
  input logic              reset,
  inst_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {START, FETCH, STALL, HALTED} state_t;

  localparam logic [31:0] PC_INC = 32'(PC_STEP);

  state_t      state, state_next;
  logic [31:0] pc;
  logic [1:0]  count;
  logic [31:0] head_pc, head_inst, tail_pc, tail_inst;
  logic [15:0] fetch_cnt;
  logic        pop, free, push, halted_o;

  assign pop  = (count != 2'd0) && bus.out_ready;
  // A slot freed by this cycle's pop can be refilled in the same cycle.
  assign free = (count != 2'd2) || pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= START;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.redirect_valid) begin
      state_next = FETCH;
    end else begin
      unique case (state)
        START:        state_next = FETCH;
        FETCH, STALL: begin
          if (!free)                           state_next = STALL;
          else if (bus.inst_code == HALT_INST) state_next = HALTED;
          else                                 state_next = FETCH;
        end
        HALTED:       state_next = HALTED;
        default:      state_next = START;
      endcase
    end
  end

  always_comb begin
    push     = ((state == FETCH) || (state == STALL)) && free && !bus.redirect_valid;
    halted_o = (state == HALTED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc        <= RESET_PC;
      count     <= '0;
      head_pc   <= '0;
      head_inst <= '0;
      tail_pc   <= '0;
      tail_inst <= '0;
      fetch_cnt <= '0;
    end else begin
      if (bus.redirect_valid) begin
        pc    <= bus.redirect_pc & ~32'd3;
        count <= '0;
      end else begin
        if (push) pc <= pc + PC_INC;
        unique case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              head_pc   <= pc;
              head_inst <= bus.inst_code;
            end else begin
              tail_pc   <= pc;
              tail_inst <= bus.inst_code;
            end
            count <= count + 2'd1;
          end
          2'b01: begin
            head_pc   <= tail_pc;
            head_inst <= tail_inst;
            count     <= count - 2'd1;
          end
          2'b11: begin
            // Count unchanged: either replace a lone head or shift and append.
            if (count == 2'd1) begin
              head_pc   <= pc;
              head_inst <= bus.inst_code;
            end else begin
              head_pc   <= tail_pc;
              head_inst <= tail_inst;
              tail_pc   <= pc;
              tail_inst <= bus.inst_code;
            end
          end
          default: ;
        endcase
      end
      if (push) fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

  assign bus.inst_add    = pc;
  assign bus.out_valid   = (count != 2'd0);
  assign bus.out_inst    = head_inst;
  assign bus.out_pc      = head_pc;
  assign bus.halted      = halted_o;
  assign bus.fetch_count = fetch_cnt;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios followed by a
// random phase, all compared every cycle against a queue-based reference model.
module tb_inst_fetch_unit;

  localparam logic [31:0] HALT = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt_en;
  logic [31:0] halt_addr;
  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  inst_fetch_unit_if bus();

  inst_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .HALT_INST(32'h0000_0073),
    .PC_STEP  (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Memory: word at A is A+0x100, except an optional halt word at halt_addr.
  assign bus.inst_code = (halt_en && bus.inst_add == halt_addr) ? HALT : bus.inst_add + 32'h100;

  // Reference model: queue of {pc, inst} plus fetch pointer and flags.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  logic        m_run;
  logic        m_halted;
  logic [15:0] m_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (halt_en && a == halt_addr) ? HALT : a + 32'h100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc     = 32'h0;
    m_run    = 1'b0;
    m_halted = 1'b0;
    m_cnt    = 16'h0;
  endtask

  task automatic check_all();
    chk("inst_add", bus.inst_add, m_pc);
    chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_pc", bus.out_pc, mq[0][63:32]);
      chk("out_inst", bus.out_inst, mq[0][31:0]);
    end
    chk("halted", 32'(bus.halted), 32'(m_halted));
    chk("fetch_count", 32'(bus.fetch_count), 32'(m_cnt));
  endtask

  // One clock: drive inputs, advance the model at the edge, check #1 later.
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    logic [31:0] w;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    @(posedge clk);
    if (rv) begin
      mq.delete();
      m_pc     = {rpc[31:2], 2'b00};
      m_halted = 1'b0;
      m_run    = 1'b1;
    end else if (!m_run) begin
      m_run = 1'b1;
    end else begin
      if (mq.size() != 0 && rdy) void'(mq.pop_front());
      if (!m_halted && mq.size() < 2) begin
        w = mem_word(m_pc);
        mq.push_back({m_pc, w});
        m_pc  = m_pc + 32'd4;
        m_cnt = m_cnt + 16'd1;
        if (w == HALT) m_halted = 1'b1;
      end
    end
    #1;
    check_all();
  endtask

  // Assert reset between edges; outputs must clear before any clock edge.
  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    chk("rst_inst_add", bus.inst_add, 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_inst", bus.out_inst, 32'h0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    chk("rst_fetch_count", 32'(bus.fetch_count), 32'h0);
    reset = 1'b1;
  endtask

  initial begin
    logic        r_rdy, r_rv;
    logic [31:0] r_rpc;

    reset              = 1'b1;
    halt_en            = 1'b0;
    halt_addr          = 32'h0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    #6;
    do_reset();

    // Sequential fetch: valid two cycles after release
    cycle(1'b1, 1'b0, 32'h0);
    chk("start_no_valid", 32'(bus.out_valid), 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("first_valid", 32'(bus.out_valid), 32'h1);
    chk("first_pc", bus.out_pc, 32'h0);
    chk("first_inst", bus.out_inst, 32'h100);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // Back-pressure: fill and stall, then drain in order
    do_reset();
    cycle(1'b1, 1'b0, 32'h0);
    repeat (6) cycle(1'b0, 1'b0, 32'h0);
    chk("stall_inst_add", bus.inst_add, 32'h8);
    chk("stall_head_pc", bus.out_pc, 32'h0);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);

    // Redirect with a full queue flushes it
    repeat (2) cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h0000_0203);
    chk("redir_bubble", 32'(bus.out_valid), 32'h0);
    chk("redir_inst_add", bus.inst_add, 32'h200);
    cycle(1'b1, 1'b0, 32'h0);
    chk("redir_target_pc", bus.out_pc, 32'h200);
    repeat (2) cycle(1'b1, 1'b0, 32'h0);

    // Halt at address 16, then resume via redirect
    halt_en   = 1'b1;
    halt_addr = 32'd16;
    cycle(1'b1, 1'b1, 32'h0);
    repeat (8) cycle(1'b1, 1'b0, 32'h0);
    chk("halt_flag", 32'(bus.halted), 32'h1);
    chk("halt_inst_add", bus.inst_add, 32'd20);
    cycle(1'b1, 1'b1, 32'h40);
    chk("halt_cleared", 32'(bus.halted), 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    chk("resume_pc", bus.out_pc, 32'h40);
    halt_en = 1'b0;

    // Full queue with simultaneous pop and push
    repeat (2) cycle(1'b0, 1'b0, 32'h0);
    repeat (4) cycle(1'b1, 1'b0, 32'h0);

    // PC wrap-around
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 32'h0);
    chk("wrap_inst_add", bus.inst_add, 32'h0);
    chk("wrap_out_pc", bus.out_pc, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rv  = ($urandom_range(0, 19) == 0);
      r_rpc = $urandom;
      if ($urandom_range(0, 24) == 0) begin
        halt_en   = 1'b1;
        halt_addr = m_pc + 32'(4 * $urandom_range(0, 6));
      end
      cycle(r_rdy, r_rv, r_rpc);
    end
    halt_en = 1'b0;

    // Reset during a stall
    do_reset();
    cycle(1'b1, 1'b0, 32'h0);
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    do_reset();
    repeat (3) cycle(1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Initiator side of the instruction-memory interface: owns the program counter and drives the 32-bit instruction address.
- Captures the 32-bit instruction code returned combinationally in the same cycle.
- Buffers fetched instructions in a 2-entry queue toward decode using a valid/ready handshake.
- Handles branch/jump redirects, back-pressure, and a halt instruction; sits between the PC logic and the ID stage.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- HALT_INST, 32'h00000073, instruction encoding that stops fetching.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- inst_add  output  32  address to instruction memory; always equals pc register.
- inst_code  input  32  instruction from memory for inst_add, valid same cycle.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  32  target address; bits [1:0] forced to 0.
- out_valid  output  1  head of queue holds a valid instruction.
- out_ready  input  1  decode accepts head this cycle.
- out_inst  output  32  instruction at queue head.
- out_pc  output  32  address of out_inst.
- halted  output  1  fetch FSM in HALTED.
- fetch_count  output  16  number of instructions pushed since reset; wraps at 16'hFFFF to 0.

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC, queue empty, out_valid=0, out_inst=0, out_pc=0.
  - halted=0, fetch_count=0, FSM=START.
- FSM states:
  - START: one cycle after reset release with no fetch → FETCH.
  - FETCH: push {pc, inst_code} when queue not full and no redirect; pc += PC_STEP.
    - Queue full → STALL.
    - Pushed inst_code == HALT_INST → HALTED (the halt instruction is itself enqueued).
  - STALL: no push; pc held; → FETCH in the cycle the queue has a free slot. Occupancy is evaluated after this cycle's pop, so a push is allowed in the same cycle as a pop.
  - HALTED: no push, pc held, halted=1. Leaves only on redirect.
- Push condition: state∈{FETCH, STALL→free}, and (count<2, or count==2 with a pop this cycle), and !redirect_valid.
- Queue:
  - 2-entry FIFO. Head drives out_inst/out_pc; out_valid = count≠0.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop keeps count unchanged.
  - Order is strictly preserved.
- Redirect (redirect_valid=1, any state except reset):
  - Highest priority.
  - Flush the queue (count=0, out_valid=0 next cycle). Any pop this cycle is still honoured by decode but has no further effect.
  - No push this cycle; pc = {redirect_pc[31:2], 2'b00}; FSM → FETCH; halted cleared next cycle.
  - The first instruction from the target is visible on out_* two cycles after the redirect edge (redirect edge, fetch edge).
- Latency: sequential fetch to out_valid = 1 cycle (pushed at edge N, visible after edge N).
- Throughput: 1 instruction/cycle while out_ready=1.
- pc arithmetic is 32-bit modulo: 32'hFFFFFFFC + 4 wraps to 0 without error.
- fetch_count increments on every push only; it is not cleared by redirect.
- inst_add is a registered output (pc), with no combinational path from any input.
- Reset asserted mid-operation aborts everything immediately, including pending queue entries.

Test Plan:
- Reset release, out_ready=1, memory word at address A = A+32'h100:
  - out_valid rises 2 cycles after reset release.
  - out_pc sequence 0,4,8,…; out_inst = out_pc+32'h100; fetch_count increments each cycle.
- out_ready=0 for 5 cycles after the first fetch:
  - Queue fills (pcs 0,4); state STALL; inst_add holds 8.
  - On out_ready=1, output 0,4,8,12 in order with no duplicates or gaps.
- redirect_valid=1, redirect_pc=32'h00000203 while queue holds 2 entries:
  - Queue flushed; next out_pc=32'h200, with out_valid=0 for 1 cycle between.
- Memory returns 32'h00000073 at address 16:
  - The halt instruction is delivered; halted=1; no further pushes; inst_add stays 20.
  - A redirect to 32'h40 clears halted and resumes at 32'h40.
- Simultaneous pop and push with a full queue:
  - Count stays 2; no drop and no duplicate.
- pc=32'hFFFFFFFC sequential fetch:
  - Next inst_add=0.
- reset asserted mid-stall:
  - All outputs go to reset values asynchronously before the next clk edge.
